// File: rtl/out_port_buffer_pkg.sv
// Shared constants for the output-port buffer: default port width and
// the encodings of the handshake-side state machine.
package out_port_buffer_pkg;

    localparam int PORT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

endpackage

// File: rtl/port_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
// The read register forwards the incoming word when it targets the slot being read.
module port_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are left uninitialised; validity is tracked by the count outside.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // raddr is the next-cycle read pointer, so a word written into the slot
    // about to be presented must bypass the array to appear one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/out_port_buffer.sv
// Captures every strobed OUT word into a small FIFO and presents it to the
// external listener over valid/ready; flags near-full and dropped words.
module out_port_buffer
    import out_port_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = PORT_W,
    parameter int DEPTH      = 4,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  outSignalEn,
    input  logic [DATA_WIDTH-1:0] outPortData,
    input  logic                  portReady,
    input  logic                  clrOverflow,
    output logic [DATA_WIDTH-1:0] portData,
    output logic                  portValid,
    output logic [ADDR_W:0]       bufCount,
    output logic                  almostFull,
    output logic                  overflow
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("out_port_buffer: DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_W:0]   count, count_nxt;
    out_state_t        state, state_nxt;
    logic              full, push, pop, drop;

    // The core cannot be stalled, so a push while full is only taken
    // when the listener frees a slot on the same edge.
    assign full = (count == CNT_FULL);
    assign pop  = (state == ST_HOLD) && portReady;
    assign push = outSignalEn && (!full || pop);
    assign drop = outSignalEn && full && !pop;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        state_nxt  = state;

        if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;

        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase

        case (state)
            ST_EMPTY: if (push) state_nxt = ST_HOLD;
            ST_HOLD:  if (count_nxt == '0) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= ST_EMPTY;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            state  <= state_nxt;
        end
    end

    // A fresh drop outranks a clear arriving on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clrOverflow) begin
            overflow <= 1'b0;
        end
    end

    port_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (outPortData),
        .raddr (rd_ptr_nxt),
        .rdata (portData)
    );

    assign portValid  = (state == ST_HOLD);
    assign bufCount   = count;
    assign almostFull = (count >= CNT_AF);

endmodule

// File: tb/tb_out_port_buffer.sv
// Directed bench for out_port_buffer: queue-based reference model checked
// every cycle, plus literal expectations for the scenarios of interest.
module tb_out_port_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          outSignalEn = 1'b0;
    logic [DW-1:0] outPortData = '0;
    logic          portReady = 1'b0;
    logic          clrOverflow = 1'b0;
    logic [DW-1:0] portData;
    logic          portValid;
    logic [AW:0]   bufCount;
    logic          almostFull;
    logic          overflow;

    int n_run  = 0;
    int n_fail = 0;

    out_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .outSignalEn (outSignalEn),
        .outPortData (outPortData),
        .portReady   (portReady),
        .clrOverflow (clrOverflow),
        .portData    (portData),
        .portValid   (portValid),
        .bufCount    (bufCount),
        .almostFull  (almostFull),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words and a sticky drop flag.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;

    always @(posedge clk or negedge reset) begin
        bit m_pop, m_push;
        if (!reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && portReady;
            m_push = outSignalEn && ((mq.size() < DEPTH) || m_pop);
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(outPortData);
            if (outSignalEn && !m_push) m_ovf = 1'b1;
            else if (clrOverflow)       m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model_valid", 32'(portValid), 32'(mq.size() != 0));
        chk("model_count", 32'(bufCount), 32'(mq.size()));
        chk("model_afull", 32'(almostFull), 32'(mq.size() >= DEPTH - 1));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("model_data", 32'(portData), 32'(mq[0]));
    end

    task automatic drive(input logic en, input logic [DW-1:0] d, input logic rdy, input logic clr);
        outSignalEn = en;
        outPortData = d;
        portReady   = rdy;
        clrOverflow = clr;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] exp_rd [4];
        exp_rd = '{16'h0002, 16'h0003, 16'h0004, 16'h0006};

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(portValid), 0);
        chk("rst_data", 32'(portData), 0);
        chk("rst_count", 32'(bufCount), 0);
        chk("rst_afull", 32'(almostFull), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b1;
        drive(0, 16'h0, 0, 0);

        // single word, then one pop
        drive(1, 16'h00A5, 0, 0);
        chk("one_valid", 32'(portValid), 1);
        chk("one_data", 32'(portData), 32'h00A5);
        chk("one_count", 32'(bufCount), 1);
        drive(0, 16'h0, 1, 0);
        chk("one_popped", 32'(portValid), 0);

        // fill to full, then drop
        drive(1, 16'h0001, 0, 0);
        drive(1, 16'h0002, 0, 0);
        chk("fill2_afull", 32'(almostFull), 0);
        drive(1, 16'h0003, 0, 0);
        chk("fill3_afull", 32'(almostFull), 1);
        chk("fill3_count", 32'(bufCount), 3);
        drive(1, 16'h0004, 0, 0);
        chk("fill4_count", 32'(bufCount), 4);
        drive(1, 16'h0005, 0, 0);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_count", 32'(bufCount), 4);
        chk("drop_head", 32'(portData), 32'h0001);

        // full with simultaneous push and pop
        drive(1, 16'h0006, 1, 0);
        chk("fullpp_count", 32'(bufCount), 4);
        chk("fullpp_head", 32'(portData), 32'h0002);

        // clear racing a drop, then clear alone
        drive(1, 16'h0007, 0, 1);
        chk("clr_vs_drop", 32'(overflow), 1);
        drive(0, 16'h0, 0, 1);
        chk("clr_alone", 32'(overflow), 0);
        chk("stall_head", 32'(portData), 32'h0002);

        for (int k = 0; k < 4; k++) begin
            chk("drain_data", 32'(portData), 32'(exp_rd[k]));
            drive(0, 16'h0, 1, 0);
        end
        chk("drain_empty", 32'(portValid), 0);

        // streaming through pointer wrap
        for (int i = 0; i < 16; i++) begin
            drive(1, 16'(16'h0010 + i), 1, 0);
            chk("wrap_data", 32'(portData), 32'(16'h0010 + i));
            chk("wrap_cnt_le1", 32'(bufCount <= 1), 1);
        end
        drive(0, 16'h0, 1, 0);
        chk("wrap_empty", 32'(portValid), 0);
        chk("wrap_ovf", 32'(overflow), 0);

        // asynchronous reset with 3 words stored
        drive(1, 16'h0AA1, 0, 0);
        drive(1, 16'h0AA2, 0, 0);
        drive(1, 16'h0AA3, 0, 0);
        chk("pre_rst_count", 32'(bufCount), 3);
        outSignalEn = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_count", 32'(bufCount), 0);
        chk("arst_valid", 32'(portValid), 0);
        chk("arst_data", 32'(portData), 0);
        chk("arst_ovf", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 16'h0, 1, 0);
        chk("post_rst_valid", 32'(portValid), 0);
        chk("post_rst_count", 32'(bufCount), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
